peak_writer: RTL and testbench
==============================

Name: peak_writer

Overview:
- Upstream producer for the VU-meter level RAM.
- Takes a stream of signed audio samples and tracks the absolute peak over a fixed window of valid samples.
- Quantizes each window peak to the RAM data width and writes it into the RAM at a circular write pointer.
- Drives the RAM's i_addr/i_rw/i_wen/i_data directly. A downstream display reader can stall writes with i_hold.

Parameters:
- IN_W, 16: sample width, signed two's complement.
- WIDTH, 2: RAM data width; quantized level width. Must be ≤ IN_W-1.
- ADDR, 2: RAM address width. The circular buffer depth is 2^ADDR.
- WINDOW, 256: valid samples per peak window. Must be ≥ 2.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_sample  in  IN_W  signed audio sample.
- i_valid  in  1  i_sample is valid this cycle.
- i_hold  in  1  downstream owns RAM; writer must not assert o_wen.
- o_addr  out  ADDR  RAM address; always equals the write pointer.
- o_rw  out  1  RAM direction; 1 = write, 0 = read.
- o_wen  out  1  RAM write enable.
- o_data  out  WIDTH  quantized level to RAM.
- o_frame  out  1  one-cycle pulse after each completed RAM write.
- o_ovf  out  1  sticky flag: a pending peak was overwritten while held.

Behaviour:
- Reset (i_rst low, async): every output is 0. State = ACC, accumulator = 0, sample count = 0, pointer = 0, pending = 0.
- Magnitude: mag = |i_sample|. The most-negative value saturates to 2^(IN_W-1)-1.
- Quantization: level = mag[IN_W-2 : IN_W-1-WIDTH], i.e. the top WIDTH magnitude bits, truncated.
- Accumulation: on each edge with i_valid=1, acc <= max(acc, mag) and count increments. i_valid=0 holds both acc and count.
- Window close: on the edge where the WINDOW-th valid sample is taken:
  - pending <= level(max(acc, mag)), including that sample.
  - acc <= 0, count <= 0.
  - State -> WR if i_hold=0, else -> WAIT.
- Accumulation continues in every state; samples arriving in WR or WAIT belong to the next window.
- States:
  - ACC: o_rw=0, o_wen=0. Stays in ACC until window close.
  - WAIT: o_rw=0, o_wen=0. Moves to WR on the first edge that samples i_hold=0.
  - WR: exactly one cycle with o_rw=1, o_wen=1, o_addr=ptr, o_data=pending. At the following edge: ptr <= ptr+1 (wraps 2^ADDR-1 -> 0), o_frame pulses for one cycle, state -> ACC.
- Write latency: o_wen is asserted in the cycle immediately after the closing edge when i_hold=0. The RAM captures the write on the edge that ends WR.
- i_hold rising while in WR does not abort the write; the write completes.
- Window closing while in WAIT: pending is replaced by the newer level, o_ovf <= 1, state stays WAIT. o_ovf clears only on reset.
- Window closing in the WR cycle itself: the new pending level is latched, and the next state is WR again if i_hold=0, else WAIT. The pointer still advances and o_frame still pulses, so back-to-back writes go to consecutive addresses.
- o_data holds the last pending value outside WR. o_addr changes only on a pointer increment.
- Reset asserted mid-window or mid-write: immediate return to the reset values above. No write is completed.

Test Plan (WINDOW=4, IN_W=16, WIDTH=2, ADDR=2):
1. Reset then idle: after release, o_addr=0, o_rw=0, o_wen=0, o_frame=0, o_ovf=0. No activity without i_valid.
2. Valid samples 0x1000, -0x4000, 0x2000, 0x0100 -> one cycle later o_wen=1, o_rw=1, o_addr=0, o_data=2'b10. Next cycle o_frame=1, o_addr=1.
3. Saturation: window containing 0x8000 -> o_data=2'b11. Window of all 0x1FFF -> o_data=2'b00. Window with max 0x2000 -> o_data=2'b01.
4. Wrap: five consecutive windows -> writes to addresses 0, 1, 2, 3, 0. Gaps in i_valid do not change results.
5. Hold: i_hold=1 at window close -> no o_wen for 10 cycles. Drop i_hold -> write one cycle later with the correct level. A second window closing during the hold -> o_ovf=1 and the newer level is written.
6. Reset mid-operation: assert i_rst low during the WR cycle -> o_wen drops immediately, o_addr=0. After release, the next window is written to address 0.

Source files
------------

// File: rtl/peak_writer_if.sv
// Sample stream in, level-RAM write port out, for the peak writer.
interface peak_writer_if #(
    parameter int IN_W  = 16,
    parameter int WIDTH = 2,
    parameter int ADDR  = 2
);
    logic [IN_W-1:0]  i_sample;
    logic             i_valid;
    logic             i_hold;
    logic [ADDR-1:0]  o_addr;
    logic             o_rw;
    logic             o_wen;
    logic [WIDTH-1:0] o_data;
    logic             o_frame;
    logic             o_ovf;

    modport master (
        output i_sample, i_valid, i_hold,
        input  o_addr, o_rw, o_wen, o_data, o_frame, o_ovf
    );

    modport slave (
        input  i_sample, i_valid, i_hold,
        output o_addr, o_rw, o_wen, o_data, o_frame, o_ovf
    );
endinterface

// File: rtl/peak_writer.sv
// Windowed absolute-peak tracker that writes quantized levels into a
// circular VU-meter RAM.
//
// state | meaning
// ------+-------------------------------------------------------------
// ACC   | accumulating, RAM port idle (read direction)
// WAIT  | a level is pending but the reader holds the RAM
// WR    | single write cycle of the pending level at the write pointer
module peak_writer #(
    parameter int IN_W   = 16,
    parameter int WIDTH  = 2,
    parameter int ADDR   = 2,
    parameter int WINDOW = 256
) (
    input  logic         i_clk,
    input  logic         i_rst,
    peak_writer_if.slave bus
);
    localparam int CNT_W = $clog2(WINDOW);
    localparam int MAG_W = IN_W - 1;

    typedef enum logic [1:0] {ST_ACC, ST_WAIT, ST_WR} state_t;

    state_t           state, state_nx;
    logic [MAG_W-1:0] acc;
    logic [MAG_W-1:0] mag;
    logic [MAG_W-1:0] mag_neg;
    logic [MAG_W-1:0] mag_max;
    logic [CNT_W-1:0] cnt;
    logic [ADDR-1:0]  ptr;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] level;
    logic             frame;
    logic             ovf;
    logic             close;

    // Magnitude with the most-negative code saturated, running max and the
    // window-close strobe. Low bits of the negation suffice because |x| fits
    // in MAG_W bits for every code except the saturated one.
    always_comb begin
        mag_neg = MAG_W'(~bus.i_sample[MAG_W-1:0]) + MAG_W'(1);
        if (!bus.i_sample[IN_W-1])
            mag = bus.i_sample[MAG_W-1:0];
        else if (bus.i_sample[MAG_W-1:0] == '0)
            mag = '1;
        else
            mag = mag_neg;
        mag_max = (mag > acc) ? mag : acc;
        level   = mag_max[MAG_W-1 -: WIDTH];
        close   = bus.i_valid && (cnt == CNT_W'(WINDOW - 1));
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            state <= ST_ACC;
        else
            state <= state_nx;
    end

    // Next-state logic; a close in WAIT only refreshes the pending level.
    always_comb begin
        state_nx = state;
        case (state)
            ST_ACC:  if (close) state_nx = bus.i_hold ? ST_WAIT : ST_WR;
            ST_WAIT: if (!close && !bus.i_hold) state_nx = ST_WR;
            ST_WR:   if (close) state_nx = bus.i_hold ? ST_WAIT : ST_WR;
                     else       state_nx = ST_ACC;
            default: state_nx = ST_ACC;
        endcase
    end

    // Datapath: accumulator, sample count, pending level, pointer, flags.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            acc     <= '0;
            cnt     <= '0;
            pending <= '0;
            ptr     <= '0;
            frame   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (bus.i_valid) begin
                if (close) begin
                    acc     <= '0;
                    cnt     <= '0;
                    pending <= level;
                end else begin
                    acc <= mag_max;
                    cnt <= cnt + CNT_W'(1);
                end
            end
            if (close && state == ST_WAIT)
                ovf <= 1'b1;
            if (state == ST_WR)
                ptr <= ptr + ADDR'(1);
            frame <= (state == ST_WR);
        end
    end

    // RAM port outputs.
    always_comb begin
        bus.o_rw  = (state == ST_WR);
        bus.o_wen = (state == ST_WR);
    end

    assign bus.o_addr  = ptr;
    assign bus.o_data  = pending;
    assign bus.o_frame = frame;
    assign bus.o_ovf   = ovf;
endmodule

// File: tb/tb_peak_writer.sv
// Directed bench for peak_writer with WINDOW=4.
module tb_peak_writer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    peak_writer_if #(.IN_W(16), .WIDTH(2), .ADDR(2)) bus ();

    peak_writer #(.IN_W(16), .WIDTH(2), .ADDR(2), .WINDOW(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0][15:0] s;    // s[3] is applied first
        int               gap;  // invalid cycles before each sample
        logic [1:0]       lvl;
        logic [1:0]       addr;
    } win_t;

    win_t vec [6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] s, input int gap);
        bus.i_valid  = 1'b0;
        bus.i_sample = 16'h8000;
        repeat (gap) tick();
        bus.i_sample = s;
        bus.i_valid  = 1'b1;
        tick();
        bus.i_valid  = 1'b0;
    endtask

    task automatic feed(input logic [3:0][15:0] s, input int gap);
        for (int k = 3; k >= 0; k--) begin
            push(s[k], gap);
            if (k > 0) chk("no_wen_mid_window", {31'd0, bus.o_wen}, 32'd0);
        end
    endtask

    task automatic expect_write(input string name, input logic [1:0] lvl, input logic [1:0] addr);
        chk({name, "_wen"},  {31'd0, bus.o_wen},  32'd1);
        chk({name, "_rw"},   {31'd0, bus.o_rw},   32'd1);
        chk({name, "_addr"}, {30'd0, bus.o_addr}, {30'd0, addr});
        chk({name, "_data"}, {30'd0, bus.o_data}, {30'd0, lvl});
    endtask

    task automatic expect_frame(input string name, input logic [1:0] next_addr);
        chk({name, "_frame"}, {31'd0, bus.o_frame}, 32'd1);
        chk({name, "_next"},  {30'd0, bus.o_addr},  {30'd0, next_addr});
        chk({name, "_idle"},  {31'd0, bus.o_wen},   32'd0);
    endtask

    initial begin
        int wen_seen;
        vec[0] = '{s: {16'h1000, 16'hC000, 16'h2000, 16'h0100}, gap: 0, lvl: 2'd2, addr: 2'd0};
        vec[1] = '{s: {16'h0100, 16'h8000, 16'h1FFF, 16'h0000}, gap: 0, lvl: 2'd3, addr: 2'd1};
        vec[2] = '{s: {16'h1FFF, 16'h1FFF, 16'h1FFF, 16'h1FFF}, gap: 0, lvl: 2'd0, addr: 2'd2};
        vec[3] = '{s: {16'h1000, 16'h2000, 16'hE001, 16'h0050}, gap: 0, lvl: 2'd1, addr: 2'd3};
        vec[4] = '{s: {16'hD000, 16'h6000, 16'h0001, 16'hFFFF}, gap: 2, lvl: 2'd3, addr: 2'd0};
        vec[5] = '{s: {16'h0000, 16'hDFFF, 16'h1000, 16'h0000}, gap: 3, lvl: 2'd1, addr: 2'd1};

        rst          = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_hold   = 1'b0;
        bus.i_sample = 16'h7FFF;
        repeat (3) tick();
        chk("rst_wen",   {31'd0, bus.o_wen},   32'd0);
        chk("rst_rw",    {31'd0, bus.o_rw},    32'd0);
        chk("rst_addr",  {30'd0, bus.o_addr},  32'd0);
        chk("rst_data",  {30'd0, bus.o_data},  32'd0);
        chk("rst_frame", {31'd0, bus.o_frame}, 32'd0);
        chk("rst_ovf",   {31'd0, bus.o_ovf},   32'd0);
        rst = 1'b1;

        // Idle: no valid samples means no activity.
        wen_seen = 0;
        repeat (8) begin
            tick();
            if (bus.o_wen || bus.o_frame) wen_seen++;
        end
        chk("idle_no_activity", wen_seen, 0);
        chk("idle_addr", {30'd0, bus.o_addr}, 32'd0);

        // Window table: quantization, saturation, gaps, pointer wrap.
        for (int i = 0; i < 6; i++) begin
            feed(vec[i].s, vec[i].gap);
            expect_write($sformatf("win%0d", i), vec[i].lvl, vec[i].addr);
            tick();
            expect_frame($sformatf("win%0d", i), vec[i].addr + 2'd1);
        end

        // Hold at close: nothing written while held, then written next cycle.
        bus.i_hold = 1'b1;
        feed({16'h1000, 16'hC000, 16'h2000, 16'h0100}, 0);
        wen_seen = 0;
        repeat (10) begin
            if (bus.o_wen) wen_seen++;
            tick();
        end
        chk("hold_no_wen", wen_seen, 0);
        chk("hold_no_ovf", {31'd0, bus.o_ovf}, 32'd0);
        bus.i_hold = 1'b0;
        tick();
        expect_write("hold_release", 2'd2, 2'd2);
        tick();
        expect_frame("hold_release", 2'd3);

        // Second window closes while held: overflow, newer level wins.
        bus.i_hold = 1'b1;
        feed({16'h2000, 16'h2000, 16'h2000, 16'h2000}, 0);
        chk("ovf_first_wen", {31'd0, bus.o_wen}, 32'd0);
        feed({16'h7FFF, 16'h0000, 16'h0000, 16'h0000}, 1);
        chk("ovf_set", {31'd0, bus.o_ovf}, 32'd1);
        chk("ovf_wen", {31'd0, bus.o_wen}, 32'd0);
        bus.i_hold = 1'b0;
        tick();
        expect_write("ovf_release", 2'd3, 2'd3);
        tick();
        expect_frame("ovf_release", 2'd0);
        chk("ovf_sticky", {31'd0, bus.o_ovf}, 32'd1);

        // Window closing in the WR cycle: back-to-back writes.
        bus.i_hold = 1'b1;
        feed({16'h4000, 16'h0000, 16'h0000, 16'h0000}, 0);
        push(16'h7FFF, 0);
        push(16'h0000, 0);
        push(16'h0000, 0);
        chk("b2b_waiting", {31'd0, bus.o_wen}, 32'd0);
        bus.i_hold = 1'b0;
        tick();
        expect_write("b2b_first", 2'd2, 2'd0);
        bus.i_sample = 16'h0000;
        bus.i_valid  = 1'b1;
        tick();
        bus.i_valid  = 1'b0;
        expect_write("b2b_second", 2'd3, 2'd1);
        chk("b2b_frame1", {31'd0, bus.o_frame}, 32'd1);
        tick();
        expect_frame("b2b_second", 2'd2);

        // Reset mid-window clears the partial peak.
        push(16'h7FFF, 0);
        push(16'h7FFF, 0);
        #1 rst = 1'b0;
        #1;
        chk("rstw_addr", {30'd0, bus.o_addr}, 32'd0);
        chk("rstw_ovf",  {31'd0, bus.o_ovf},  32'd0);
        tick();
        rst = 1'b1;
        feed({16'h2000, 16'h2000, 16'h2000, 16'h2000}, 0);
        expect_write("rstw_after", 2'd1, 2'd0);
        tick();
        expect_frame("rstw_after", 2'd1);

        // Reset during the WR cycle aborts the write.
        feed({16'h4000, 16'h0000, 16'h0000, 16'h0000}, 0);
        expect_write("rstwr_pre", 2'd2, 2'd1);
        rst = 1'b0;
        #1;
        chk("rstwr_wen",   {31'd0, bus.o_wen},   32'd0);
        chk("rstwr_rw",    {31'd0, bus.o_rw},    32'd0);
        chk("rstwr_addr",  {30'd0, bus.o_addr},  32'd0);
        chk("rstwr_data",  {30'd0, bus.o_data},  32'd0);
        tick();
        chk("rstwr_frame", {31'd0, bus.o_frame}, 32'd0);
        rst = 1'b1;
        feed({16'h0000, 16'h9000, 16'h0000, 16'h0000}, 0);
        expect_write("rstwr_after", 2'd3, 2'd0);
        tick();
        expect_frame("rstwr_after", 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
